multi_countdown_timer: RTL and testbench

//  NUM_CH independent seconds countdown timers, each with its own sub-second prescaler.

---
 rtl/multi_countdown_timer.sv | 150 +++++++++++++++
 tb/tb_multi_countdown_timer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_countdown_timer.sv
// NUM_CH independent seconds countdown timers, each with its own sub-second prescaler,
// per-channel pause and a one-cycle expiry pulse. Optional feature macro: TIMER_AUTORELOAD_EN.
module multi_countdown_timer #(
    parameter int NUM_CH        = 4,
    parameter int SEC_W         = 4,
    parameter int TICKS_PER_SEC = 25000000,
    parameter int RST_SEC       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       set,
    input  logic [NUM_CH*SEC_W-1:0] new_sec,
    input  logic [NUM_CH-1:0]       pause,
    output logic [NUM_CH*SEC_W-1:0] cur_sec,
    output logic [NUM_CH-1:0]       running,
    output logic [NUM_CH-1:0]       expired
);
    localparam int                TCNT_W    = $clog2(TICKS_PER_SEC);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICKS_PER_SEC - 1);
    localparam logic [TCNT_W-1:0] TCNT_ZERO = {TCNT_W{1'b0}};
    localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);
    localparam logic [SEC_W-1:0]  SEC_RST   = SEC_W'(RST_SEC);
    localparam logic [SEC_W-1:0]  SEC_ZERO  = {SEC_W{1'b0}};
    localparam logic [SEC_W-1:0]  SEC_ONE   = SEC_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam state_e ST_RST = (RST_SEC != 0) ? ST_RUN : ST_IDLE;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_e            state_q, state_d;
        logic [TCNT_W-1:0] tcnt_q, tcnt_d;
        logic [SEC_W-1:0]  sec_q, sec_d;
        logic              exp_q, exp_d;
        logic [SEC_W-1:0]  new_s, reload_s;
        logic              set_s, pause_s, pend_s, cnt_en_s, wrap_s, expire_s;

        assign set_s   = set[gi];
        assign pause_s = pause[gi];
        assign new_s   = new_sec[gi*SEC_W +: SEC_W];

`ifdef TIMER_AUTORELOAD_EN
        logic [SEC_W-1:0] reload_q;

        // Reload value tracks the most recent load strobe
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                reload_q <= SEC_RST;
            end else if (set_s) begin
                reload_q <= new_s;
            end else begin
                reload_q <= reload_q;
            end
        end

        assign reload_s = reload_q;
        // The cycle after an expiry pulse is spent loading the reload value
        assign pend_s   = exp_q && (state_q != ST_IDLE);
`else
        assign reload_s = SEC_ZERO;
        assign pend_s   = 1'b0;
`endif

        // HOLD with pause released counts in that same cycle, so a pause costs exactly its length
        assign cnt_en_s = (state_q != ST_IDLE) && !pause_s && !pend_s;
        assign wrap_s   = cnt_en_s && (tcnt_q == TCNT_LAST);
        assign expire_s = wrap_s && (sec_q == SEC_ONE);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= ST_RST;
                tcnt_q  <= TCNT_ZERO;
                sec_q   <= SEC_RST;
                exp_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                tcnt_q  <= tcnt_d;
                sec_q   <= sec_d;
                exp_q   <= exp_d;
            end
        end

        always_comb begin
            state_d = state_q;
            if (set_s) begin
                if (new_s == SEC_ZERO) begin
                    state_d = ST_IDLE;
                end else if (pause_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_RUN;
                end
            end else begin
                case (state_q)
                    ST_IDLE: state_d = ST_IDLE;
                    ST_RUN, ST_HOLD: begin
                        if (pend_s) begin
                            if (reload_s == SEC_ZERO) begin
                                state_d = ST_IDLE;
                            end else if (pause_s) begin
                                state_d = ST_HOLD;
                            end else begin
                                state_d = ST_RUN;
                            end
                        end else if (pause_s) begin
                            state_d = ST_HOLD;
                        end else if (expire_s) begin
                            state_d = (reload_s != SEC_ZERO) ? ST_RUN : ST_IDLE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        always_comb begin
            tcnt_d = tcnt_q;
            sec_d  = sec_q;
            exp_d  = 1'b0;
            if (set_s) begin
                tcnt_d = TCNT_ZERO;
                sec_d  = new_s;
            end else if (state_q == ST_IDLE) begin
                tcnt_d = TCNT_ZERO;
            end else if (pend_s) begin
                tcnt_d = TCNT_ZERO;
                sec_d  = reload_s;
            end else if (wrap_s) begin
                tcnt_d = TCNT_ZERO;
                sec_d  = (sec_q != SEC_ZERO) ? (sec_q - SEC_ONE) : SEC_ZERO;
                exp_d  = expire_s;
            end else if (cnt_en_s) begin
                tcnt_d = tcnt_q + TCNT_ONE;
            end else begin
                tcnt_d = tcnt_q;
            end
        end

        assign cur_sec[gi*SEC_W +: SEC_W] = sec_q;
        assign running[gi]                = (state_q == ST_RUN);
        assign expired[gi]                = exp_q;
    end

endmodule

// File: tb/tb_multi_countdown_timer.sv
// Self-checking bench for multi_countdown_timer: directed vector table, corner sequences and
// randomized traffic compared against a behavioural per-channel model.
module tb_multi_countdown_timer;
    localparam int NUM_CH  = 2;
    localparam int SEC_W   = 4;
    localparam int TPS     = 4;
    localparam int RST_SEC = 4;
`ifdef TIMER_AUTORELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       set = '0;
    logic [NUM_CH*SEC_W-1:0] new_sec = '0;
    logic [NUM_CH-1:0]       pause = '0;
    logic [NUM_CH*SEC_W-1:0] cur_sec;
    logic [NUM_CH-1:0]       running;
    logic [NUM_CH-1:0]       expired;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: whole seconds left, cycles elapsed in the current second, flags
    int m_sec[NUM_CH];
    int m_phase[NUM_CH];
    int m_reload[NUM_CH];
    bit m_active[NUM_CH];
    bit m_paused[NUM_CH];
    bit m_pend[NUM_CH];
    bit m_exp[NUM_CH];

    typedef struct {
        logic       set;
        logic [3:0] nsec;
        logic       pause;
        int         ncyc;
        logic [3:0] e_sec;
        logic       e_run;
        logic       e_exp;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl[NV];

    multi_countdown_timer #(
        .NUM_CH(NUM_CH), .SEC_W(SEC_W), .TICKS_PER_SEC(TPS), .RST_SEC(RST_SEC)
    ) dut (
        .clk(clk), .rst(rst), .set(set), .new_sec(new_sec), .pause(pause),
        .cur_sec(cur_sec), .running(running), .expired(expired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            m_sec[ch]    = RST_SEC;
            m_phase[ch]  = 0;
            m_reload[ch] = RST_SEC;
            m_active[ch] = (RST_SEC != 0);
            m_paused[ch] = 1'b0;
            m_pend[ch]   = 1'b0;
            m_exp[ch]    = 1'b0;
        end
    endtask

    task automatic model_clock(input logic [NUM_CH-1:0] s, input logic [NUM_CH*SEC_W-1:0] ns,
                               input logic [NUM_CH-1:0] p);
        for (int ch = 0; ch < NUM_CH; ch++) begin
            int nv;
            nv = int'(ns[ch*SEC_W +: SEC_W]);
            m_exp[ch] = 1'b0;
            if (s[ch]) begin
                m_sec[ch]    = nv;
                m_phase[ch]  = 0;
                m_active[ch] = (nv != 0);
                m_paused[ch] = p[ch];
                m_pend[ch]   = 1'b0;
                if (AR) m_reload[ch] = nv;
            end else if (!m_active[ch]) begin
                m_phase[ch] = 0;
            end else if (m_pend[ch]) begin
                m_pend[ch]   = 1'b0;
                m_sec[ch]    = m_reload[ch];
                m_phase[ch]  = 0;
                m_active[ch] = (m_reload[ch] != 0);
                m_paused[ch] = p[ch];
            end else if (p[ch]) begin
                m_paused[ch] = 1'b1;
            end else begin
                m_paused[ch] = 1'b0;
                m_phase[ch]++;
                if (m_phase[ch] == TPS) begin
                    m_phase[ch] = 0;
                    m_sec[ch]--;
                    if (m_sec[ch] == 0) begin
                        m_exp[ch] = 1'b1;
                        if (AR && m_reload[ch] != 0) m_pend[ch] = 1'b1;
                        else m_active[ch] = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic model_compare();
        for (int ch = 0; ch < NUM_CH; ch++) begin
            check($sformatf("model cur_sec ch%0d", ch), int'(cur_sec[ch*SEC_W +: SEC_W]), m_sec[ch]);
            check($sformatf("model running ch%0d", ch), int'(running[ch]),
                  int'(m_active[ch] && !m_paused[ch]));
            check($sformatf("model expired ch%0d", ch), int'(expired[ch]), int'(m_exp[ch]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_clock(set, new_sec, pause);
        #1;
        model_compare();
    endtask

    initial begin
        tbl[0]  = '{1'b0, 4'd0, 1'b0, 1,   4'd4, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 4'd0, 1'b0, 3,   4'd3, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 4'd0, 1'b0, 4,   4'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 4'd0, 1'b0, 4,   4'd1, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 4'd0, 1'b0, 3,   4'd1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 4'd0, 1'b0, 1,   4'd0, AR,   1'b1};
        tbl[6]  = '{1'b0, 4'd0, 1'b0, 1,   (AR ? 4'd4 : 4'd0), AR, 1'b0};
        tbl[7]  = '{1'b1, 4'd2, 1'b0, 1,   4'd2, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 4'd0, 1'b0, 4,   4'd1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 4'd0, 1'b0, 3,   4'd1, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'd5, 1'b0, 1,   4'd5, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 4'd0, 1'b0, 1,   4'd5, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 4'd0, 1'b0, 1,   4'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 4'd0, 1'b0, 100, 4'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 4'd0, 1'b1, 5,   4'd0, 1'b0, 1'b0};
        tbl[15] = '{1'b1, 4'd3, 1'b0, 1,   4'd3, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 4'd0, 1'b0, 2,   4'd3, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 4'd0, 1'b1, 10,  4'd3, 1'b0, 1'b0};
        tbl[18] = '{1'b0, 4'd0, 1'b0, 1,   4'd3, 1'b1, 1'b0};
        tbl[19] = '{1'b0, 4'd0, 1'b0, 1,   4'd2, 1'b1, 1'b0};
        tbl[20] = '{1'b0, 4'd0, 1'b0, 7,   4'd1, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 4'd0, 1'b0, 1,   4'd0, AR,   1'b1};

        // Reset state, held across clock edges
        repeat (2) @(posedge clk);
        #1;
        check("reset cur_sec ch0", int'(cur_sec[3:0]), RST_SEC);
        check("reset cur_sec ch1", int'(cur_sec[7:4]), RST_SEC);
        check("reset running", int'(running), 3);
        check("reset expired", int'(expired), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Directed vectors on ch0: countdown from reset, late set, zero load, pause
        for (int k = 0; k < NV; k++) begin
            set[0]       = tbl[k].set;
            new_sec[3:0] = tbl[k].nsec;
            pause[0]     = tbl[k].pause;
            repeat (tbl[k].ncyc) step();
            check($sformatf("vec%0d cur_sec ch0", k), int'(cur_sec[3:0]), int'(tbl[k].e_sec));
            check($sformatf("vec%0d running ch0", k), int'(running[0]), int'(tbl[k].e_run));
            check($sformatf("vec%0d expired ch0", k), int'(expired[0]), int'(tbl[k].e_exp));
        end
        set = '0; pause = '0; new_sec = '0;

        // ch1 loaded with 9 reaches 0 after 36 cycles
        set[1] = 1'b1; new_sec[7:4] = 4'd9;
        step();
        set[1] = 1'b0; new_sec[7:4] = 4'd0;
        check("ch1 load 9", int'(cur_sec[7:4]), 9);
        repeat (35) step();
        check("ch1 one cycle before expiry", int'(cur_sec[7:4]), 1);
        check("ch1 no early expiry", int'(expired[1]), 0);
        step();
        check("ch1 expiry value", int'(cur_sec[7:4]), 0);
        check("ch1 expiry pulse", int'(expired[1]), 1);

`ifdef TIMER_AUTORELOAD_EN
        // Autoreload sequence 2,1,0,2,1,0
        set[0] = 1'b1; new_sec[3:0] = 4'd2;
        step();
        set[0] = 1'b0; new_sec[3:0] = 4'd0;
        check("ar load 2", int'(cur_sec[3:0]), 2);
        repeat (8) step();
        check("ar first expiry value", int'(cur_sec[3:0]), 0);
        check("ar first expiry pulse", int'(expired[0]), 1);
        check("ar running at expiry", int'(running[0]), 1);
        step();
        check("ar reloaded", int'(cur_sec[3:0]), 2);
        check("ar pulse one cycle", int'(expired[0]), 0);
        repeat (8) step();
        check("ar second expiry value", int'(cur_sec[3:0]), 0);
        check("ar second expiry pulse", int'(expired[0]), 1);
`endif

        // Reset in the middle of a count discards progress
        set[0] = 1'b1; new_sec[3:0] = 4'd3;
        step();
        set[0] = 1'b0; new_sec[3:0] = 4'd0;
        repeat (5) step();
        rst = 1'b1;
        #1;
        model_reset();
        check("midreset cur_sec ch0", int'(cur_sec[3:0]), RST_SEC);
        check("midreset running ch0", int'(running[0]), 1);
        check("midreset expired", int'(expired), 0);
        @(posedge clk);
        #1;
        check("midreset held cur_sec ch0", int'(cur_sec[3:0]), RST_SEC);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (16) step();
        check("postreset expiry value", int'(cur_sec[3:0]), 0);
        check("postreset expiry pulse", int'(expired[0]), 1);
        step();
        check("postreset after expiry", int'(cur_sec[3:0]), AR ? RST_SEC : 0);

        // Randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                set[ch] = ($urandom_range(0, 19) == 0);
                new_sec[ch*SEC_W +: SEC_W] = ($urandom_range(0, 3) == 0) ?
                                             4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
                pause[ch] = ($urandom_range(0, 5) == 0);
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
